mmu_data_responder: RTL and testbench

//  Memory-side responder for the core's mem_valid / mmu_data_ready handshake that the pipeline registers stall on.

---
 rtl/mmu_data_responder_pkg.sv | 30 +++
 rtl/mmu_data_responder_lane_align.sv | 52 +++++
 rtl/mmu_data_responder.sv | 164 ++++++++++++++++
 tb/tb_mmu_data_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_data_responder_pkg.sv
// Shared definitions for the memory-side data responder.
// Holds the FSM state encoding, the access-size codes and a helper that
// returns the zero-extension mask for a given access size.
package mmu_data_responder_pkg;

  // FSM states. The numeric values are visible on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Access size codes as carried on mem_size. Code 2'b11 is not a legal size.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Bits kept from a right-aligned load word for each size.
  function automatic logic [31:0] size_keep(input logic [1:0] size);
    logic [31:0] keep;
    case (size)
      SZ_B:    keep = 32'h0000_00FF;
      SZ_H:    keep = 32'h0000_FFFF;
      SZ_W:    keep = 32'hFFFF_FFFF;
      default: keep = 32'h0000_0000;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/mmu_data_responder_lane_align.sv
// Combinational byte-lane alignment for a word-wide RAM.
// Ports:
//   size_i      access size code (byte/half/word, 2'b11 illegal)
//   addr_lo_i   byte offset within the word (addr[1:0])
//   wdata_i     LSB-aligned store data
//   rdata_i     raw RAM read word
//   wmask_o     byte enables for the addressed lanes
//   wdata_o     store data shifted onto the addressed lanes
//   rdata_o     load data shifted down to bit 0 and zero-extended to size
//   misalign_o  access crosses its natural alignment or size is illegal
module mmu_data_responder_lane_align
  import mmu_data_responder_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [4:0] shamt;

  always_comb begin
    shamt   = {addr_lo_i, 3'b000};
    wdata_o = wdata_i << shamt;
    rdata_o = (rdata_i >> shamt) & size_keep(size_i);
    case (size_i)
      SZ_B: begin
        wmask_o    = 4'b0001 << addr_lo_i;
        misalign_o = 1'b0;
      end
      SZ_H: begin
        // For offset 3 the shifted mask truncates, but that offset is
        // already flagged misaligned so the mask is never used.
        wmask_o    = 4'b0011 << addr_lo_i;
        misalign_o = addr_lo_i[0];
      end
      SZ_W: begin
        wmask_o    = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      default: begin
        wmask_o    = 4'b0000;
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mmu_data_responder.sv
// Memory-side responder for the core's mem_valid / mmu_data_ready handshake.
// One load or store is accepted per transaction, waits LATENCY cycles, is
// run against a synchronous word-wide RAM, and completes with a single-cycle
// mmu_data_ready pulse. Misaligned, illegal-size or out-of-range requests
// complete one cycle after acceptance with mmu_fault=1 and never touch RAM.
//
// Handshake: the core raises mem_valid and holds it (fields stable) until it
// sees mmu_data_ready=1 for one cycle. A request is taken only in IDLE; the
// ready cycle itself ignores mem_valid, so a held or new request is taken on
// the following IDLE cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_valid/we/size/addr/wdata   request from the core
//   mmu_data_ready    one-cycle completion pulse
//   mmu_rdata         LSB-aligned zero-extended load data (valid with ready)
//   mmu_fault         fault flag (valid with ready)
//   ram_en/we/addr/wmask/wdata     synchronous RAM port, combinational
//   ram_rdata         RAM read data, one cycle after ram_en
//   dbg_state         current FSM state (state_e encoding)
module mmu_data_responder
  import mmu_data_responder_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int RAM_AW  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mmu_data_ready,
  output logic [31:0]       mmu_rdata,
  output logic              mmu_fault,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_wmask,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        dbg_state
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("mmu_data_responder: LATENCY must be at least 1");
  end

  // The counter only ever holds LATENCY-1 down to 0.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [RAM_AW+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                fault_q, fault_d;

  logic [1:0]  la_size;
  logic [1:0]  la_addr_lo;
  logic [3:0]  la_wmask;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;
  logic        la_misalign;
  logic        out_of_range;

  // In IDLE the aligner looks at the incoming request so the fault check is
  // made at acceptance; in every other state it works on the latched request.
  assign la_size    = (state_q == ST_IDLE) ? mem_size      : size_q;
  assign la_addr_lo = (state_q == ST_IDLE) ? mem_addr[1:0] : addr_q[1:0];

  // Any address bit above the RAM's byte range makes the access invalid.
  assign out_of_range = (mem_addr >> (RAM_AW + 2)) != 32'd0;

  mmu_data_responder_lane_align u_lane_align (
    .size_i     (la_size),
    .addr_lo_i  (la_addr_lo),
    .wdata_i    (wdata_q),
    .rdata_i    (ram_rdata),
    .wmask_o    (la_wmask),
    .wdata_o    (la_wdata),
    .rdata_o    (la_rdata),
    .misalign_o (la_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    size_d         = size_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    fault_d        = fault_q;
    ram_en         = 1'b0;
    mmu_data_ready = 1'b0;
    mmu_rdata      = 32'd0;
    mmu_fault      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          we_d    = mem_we;
          size_d  = mem_size;
          addr_d  = mem_addr[RAM_AW+1:0];
          wdata_d = mem_wdata;
          cnt_d   = CNT_INIT;
          fault_d = la_misalign | out_of_range;
          state_d = fault_d ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ram_en  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        mmu_data_ready = 1'b1;
        mmu_fault      = fault_q;
        // The RAM read issued in the last WAIT cycle lands here.
        if (!fault_q && !we_q) begin
          mmu_rdata = la_rdata;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM port is quiet (all zero) except in the single access cycle.
  assign ram_we    = ram_en & we_q;
  assign ram_addr  = ram_en ? addr_q[RAM_AW+1:2] : '0;
  assign ram_wmask = ram_en ? la_wmask : 4'b0000;
  assign ram_wdata = ram_en ? la_wdata : 32'd0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mmu_data_responder.sv
// Bench for mmu_data_responder: instance 0 uses LATENCY=1, instance 1 uses
// LATENCY=3, each with its own behavioural synchronous RAM.
module tb_mmu_data_responder;

  logic clk;
  logic rst_n;

  // Instance 0 (LATENCY=1)
  logic        v0, we0, rdy0, flt0, en0, rwe0;
  logic [1:0]  sz0, st0;
  logic [31:0] ad0, wd0, rd0, rwd0, rrd0;
  logic [11:0] raddr0;
  logic [3:0]  msk0;
  // Instance 1 (LATENCY=3)
  logic        v1, we1, rdy1, flt1, en1, rwe1;
  logic [1:0]  sz1, st1;
  logic [31:0] ad1, wd1, rd1, rwd1, rrd1;
  logic [11:0] raddr1;
  logic [3:0]  msk1;

  logic [31:0] ram0 [0:4095];
  logic [31:0] ram1 [0:4095];
  logic        abort_hit;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  mmu_data_responder #(.LATENCY(1), .RAM_AW(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_valid(v0), .mem_we(we0), .mem_size(sz0),
    .mem_addr(ad0), .mem_wdata(wd0), .mmu_data_ready(rdy0), .mmu_rdata(rd0),
    .mmu_fault(flt0), .ram_en(en0), .ram_we(rwe0), .ram_addr(raddr0),
    .ram_wmask(msk0), .ram_wdata(rwd0), .ram_rdata(rrd0), .dbg_state(st0)
  );

  mmu_data_responder #(.LATENCY(3), .RAM_AW(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_valid(v1), .mem_we(we1), .mem_size(sz1),
    .mem_addr(ad1), .mem_wdata(wd1), .mmu_data_ready(rdy1), .mmu_rdata(rd1),
    .mmu_fault(flt1), .ram_en(en1), .ram_we(rwe1), .ram_addr(raddr1),
    .ram_wmask(msk1), .ram_wdata(rwd1), .ram_rdata(rrd1), .dbg_state(st1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- RAM models ----------------
  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram0[i] = 32'd0;
      ram1[i] = 32'd0;
    end
    rrd0 = 32'd0;
    rrd1 = 32'd0;
    abort_hit = 1'b0;
  end

  always @(posedge clk) begin
    if (en0) begin
      rrd0 <= ram0[raddr0];
      for (int b = 0; b < 4; b++)
        if (rwe0 && msk0[b]) ram0[raddr0][8*b +: 8] <= rwd0[8*b +: 8];
    end
    if (en1) begin
      rrd1 <= ram1[raddr1];
      for (int b = 0; b < 4; b++)
        if (rwe1 && msk1[b]) ram1[raddr1][8*b +: 8] <= rwd1[8*b +: 8];
    end
    if (en1 && rwe1 && raddr1 == 12'h010) abort_hit <= 1'b1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int sel, input logic v, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      v0 = v; we0 = we; sz0 = sz; ad0 = a; wd0 = d;
    end else begin
      v1 = v; we1 = we; sz1 = sz; ad1 = a; wd1 = d;
    end
  endtask

  task automatic get_obs(input int sel, output logic rdy, output logic en, output logic we,
                         output logic [11:0] a, output logic [3:0] m, output logic [31:0] wd);
    if (sel == 0) begin
      rdy = rdy0; en = en0; we = rwe0; a = raddr0; m = msk0; wd = rwd0;
    end else begin
      rdy = rdy1; en = en1; we = rwe1; a = raddr1; m = msk1; wd = rwd1;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic prev0, prev1;
    logic [32:0] e;
    prev0 = 1'b0;
    prev1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy0) begin
        chk("ready_double_0", {31'd0, prev0}, 32'd0);
        if (exp_q0.size() == 0) chk("unexpected_ready_0", 32'd1, 32'd0);
        else begin
          e = exp_q0.pop_front();
          chk("fault_0", {31'd0, flt0}, {31'd0, e[32]});
          chk("rdata_0", rd0, e[31:0]);
        end
      end
      if (rdy1) begin
        chk("ready_double_1", {31'd0, prev1}, 32'd0);
        if (exp_q1.size() == 0) chk("unexpected_ready_1", 32'd1, 32'd0);
        else begin
          e = exp_q1.pop_front();
          chk("fault_1", {31'd0, flt1}, {31'd0, e[32]});
          chk("rdata_1", rd1, e[31:0]);
        end
      end
      prev0 = rdy0;
      prev1 = rdy1;
    end
  end

  // ---------------- driver: one full transaction ----------------
  task automatic run_req(input int sel, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic exp_fault, input logic [31:0] exp_rdata,
                         input logic [3:0] exp_mask);
    int lat, rdy_cyc, en_cyc, en_cnt;
    logic o_rdy, o_en, o_we, e_we;
    logic [11:0] o_a, e_a;
    logic [3:0] o_m, e_m;
    logic [31:0] o_wd, e_wd;
    lat = (sel == 0) ? 1 : 3;
    rdy_cyc = 0; en_cyc = 0; en_cnt = 0;
    e_we = 1'b0; e_a = '0; e_m = '0; e_wd = '0;
    if (sel == 0) exp_q0.push_back({exp_fault, exp_rdata});
    else          exp_q1.push_back({exp_fault, exp_rdata});
    @(negedge clk);
    set_req(sel, 1'b1, we, sz, a, d);
    for (int c = 1; c <= 20 && rdy_cyc == 0; c++) begin
      @(posedge clk);
      #1;
      get_obs(sel, o_rdy, o_en, o_we, o_a, o_m, o_wd);
      if (o_en) begin
        en_cnt++; en_cyc = c; e_we = o_we; e_a = o_a; e_m = o_m; e_wd = o_wd;
      end
      if (o_rdy) rdy_cyc = c;
    end
    set_req(sel, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("ready_latency", rdy_cyc, exp_fault ? 32'd1 : 32'(lat + 1));
    chk("ram_en_count", en_cnt, exp_fault ? 32'd0 : 32'd1);
    if (!exp_fault) begin
      chk("ram_en_cycle", en_cyc, lat);
      chk("ram_we", {31'd0, e_we}, {31'd0, we});
      chk("ram_addr", {20'd0, e_a}, {20'd0, a[13:2]});
      chk("ram_wmask", {28'd0, e_m}, {28'd0, exp_mask});
      chk("ram_wdata", e_wd, d << (8 * a[1:0]));
    end
    @(posedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          sel;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [31:0] rdata;
    logic [3:0]  mask;
  } vec_t;

  function automatic vec_t mk(int sel, logic we, logic [1:0] sz, logic [31:0] a,
                              logic [31:0] d, logic f, logic [31:0] r, logic [3:0] m);
    vec_t v;
    v.sel = sel; v.we = we; v.sz = sz; v.addr = a; v.wdata = d;
    v.fault = f; v.rdata = r; v.mask = m;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    int r1, r2, e2, en_cnt;
    logic o_rdy, o_en, o_we;
    logic [11:0] o_a;
    logic [3:0] o_m;
    logic [31:0] o_wd, rnd_a, rnd_d;
    int lane;

    vecs[0]  = mk(0, 1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         4'hF);
    vecs[1]  = mk(0, 0, 2'b00, 32'h0000_0013, 32'h0,         0, 32'h0000_00DE, 4'h8);
    vecs[2]  = mk(0, 0, 2'b01, 32'h0000_0011, 32'h0,         1, 32'h0,         4'h0);
    vecs[3]  = mk(0, 0, 2'b10, 32'h0001_0000, 32'h0,         1, 32'h0,         4'h0);
    vecs[4]  = mk(0, 0, 2'b11, 32'h0000_0020, 32'h0,         1, 32'h0,         4'h0);
    vecs[5]  = mk(0, 0, 2'b01, 32'h0000_0012, 32'h0,         0, 32'h0000_DEAD, 4'hC);
    vecs[6]  = mk(0, 1, 2'b00, 32'h0000_0011, 32'h0000_00A5, 0, 32'h0,         4'h2);
    vecs[7]  = mk(0, 0, 2'b10, 32'h0000_0010, 32'h0,         0, 32'hDEAD_A5EF, 4'hF);
    vecs[8]  = mk(0, 1, 2'b01, 32'h0000_3FFE, 32'h0000_1234, 0, 32'h0,         4'hC);
    vecs[9]  = mk(0, 0, 2'b01, 32'h0000_3FFE, 32'h0,         0, 32'h0000_1234, 4'hC);
    vecs[10] = mk(0, 0, 2'b00, 32'h0000_4000, 32'h0,         1, 32'h0,         4'h0);
    vecs[11] = mk(0, 1, 2'b10, 32'h0000_0012, 32'h1111_2222, 1, 32'h0,         4'h0);
    vecs[12] = mk(1, 1, 2'b01, 32'h0000_0022, 32'h0000_ABCD, 0, 32'h0,         4'hC);
    vecs[13] = mk(1, 0, 2'b10, 32'h0000_0020, 32'h0,         0, 32'hABCD_0000, 4'hF);
    vecs[14] = mk(1, 0, 2'b00, 32'h0000_0023, 32'h0,         0, 32'h0000_00AB, 4'h8);
    vecs[15] = mk(1, 0, 2'b00, 32'h0000_0010, 32'h0,         0, 32'h0,         4'h1);

    // Reset state
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ready", {31'd0, rdy0}, 32'd0);
    chk("reset_ram_en", {31'd0, en0}, 32'd0);
    chk("reset_rdata", rd0, 32'd0);
    chk("reset_state", {30'd0, st0}, 32'd0);
    chk("reset_state_1", {30'd0, st1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Table-driven vectors
    for (int i = 0; i < 16; i++)
      run_req(vecs[i].sel, vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata,
              vecs[i].fault, vecs[i].rdata, vecs[i].mask);

    // Random word stores read back one byte lane at a time
    for (int i = 0; i < 6; i++) begin
      rnd_a = {18'd0, 12'($urandom_range(256, 4095)), 2'b00};
      rnd_d = $urandom;
      lane  = $urandom_range(0, 3);
      run_req(0, 1'b1, 2'b10, rnd_a, rnd_d, 1'b0, 32'd0, 4'hF);
      run_req(0, 1'b0, 2'b00, rnd_a + 32'(lane), 32'd0, 1'b0,
              (rnd_d >> (8 * lane)) & 32'hFF, 4'(4'b0001 << lane));
    end

    // Back-to-back: valid held through ready, next request follows directly
    exp_q0.push_back({1'b0, 32'd0});
    exp_q0.push_back({1'b0, 32'h1122_3344});
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 2'b10, 32'h0000_0020, 32'h1122_3344);
    r1 = 0; r2 = 0; e2 = 0; en_cnt = 0;
    for (int c = 1; c <= 30 && r2 == 0; c++) begin
      @(posedge clk);
      #1;
      get_obs(0, o_rdy, o_en, o_we, o_a, o_m, o_wd);
      if (o_en) en_cnt++;
      if (o_en && !o_we && e2 == 0) e2 = c;
      if (o_rdy) begin
        if (r1 == 0) begin
          r1 = c;
          set_req(0, 1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'd0);
        end else r2 = c;
      end
    end
    set_req(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk);
    chk("b2b_first_ready", r1, 32'd2);
    chk("b2b_second_en_gap", e2 - r1, 32'd2);
    chk("b2b_second_ready_gap", r2 - r1, 32'd3);
    chk("b2b_en_count", en_cnt, 32'd2);

    // Reset during WAIT of a store on the LATENCY=3 instance
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 2'b01, 32'h0000_0040, 32'h0000_5555);
    @(posedge clk);
    #1;
    chk("abort_in_wait", {30'd0, st1}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", {30'd0, st1}, 32'd0);
    chk("abort_ready", {31'd0, rdy1}, 32'd0);
    chk("abort_ram_en", {31'd0, en1}, 32'd0);
    chk("abort_ram_we", {31'd0, rwe1}, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_write", {31'd0, abort_hit}, 32'd0);
    run_req(1, 1'b0, 2'b01, 32'h0000_0042, 32'd0, 1'b0, 32'd0, 4'hC);
    run_req(1, 1'b1, 2'b10, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 32'd0, 4'hF);
    run_req(1, 1'b0, 2'b01, 32'h0000_0040, 32'd0, 1'b0, 32'h0000_F00D, 4'h3);

    repeat (4) @(posedge clk);
    chk("queue0_drained", exp_q0.size(), 32'd0);
    chk("queue1_drained", exp_q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
